// File: rtl/sram_access_arbiter_if.sv
// Client-side bus of the SRAM arbiter: request, address, write data and
// write enable from the client; grant and read-valid back from the arbiter.
interface sram_access_arbiter_if;
  logic        req;
  logic [17:0] address;
  logic [15:0] write_data;
  logic        we_n;
  logic        gnt;
  logic        read_valid;

  modport master (
    output req,
    output address,
    output write_data,
    output we_n,
    input  gnt,
    input  read_valid
  );

  modport slave (
    input  req,
    input  address,
    input  write_data,
    input  we_n,
    output gnt,
    output read_valid
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Shares the external SRAM port between clients A and B (round-robin with
// bounded bursts) and the BIST engine, which takes over on a bist_run edge.
module sram_access_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 8
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  bist_run,
  sram_access_arbiter_if.slave  client_a,
  sram_access_arbiter_if.slave  client_b,
  output logic [15:0]           rd_data,
  output logic                  BIST_start,
  input  logic [17:0]           BIST_address,
  input  logic [15:0]           BIST_write_data,
  input  logic                  BIST_we_n,
  input  logic                  BIST_finish,
  input  logic                  BIST_mismatch,
  output logic [17:0]           SRAM_address,
  output logic [15:0]           SRAM_write_data,
  output logic                  SRAM_we_n,
  input  logic [15:0]           SRAM_read_data,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail
);

  localparam int CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int PHASE_W = $clog2(READ_LATENCY + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT_A,
    S_GNT_B,
    S_BIST_DRAIN,
    S_BIST_START,
    S_BIST_WAIT
  } state_t;

  state_t               state;
  logic                 a_gnt;
  logic                 b_gnt;
  logic                 rr_ptr_b;
  logic [CNT_W-1:0]     burst_cnt;
  logic [PHASE_W-1:0]   phase_cnt;
  logic                 bist_pending;
  logic                 bist_run_q;
  logic [READ_LATENCY-1:0] tag_a;
  logic [READ_LATENCY-1:0] tag_b;

  logic bist_rise;
  logic burst_last;
  logic a_release;
  logic b_release;
  logic issue_a;
  logic issue_b;
  logic bist_owns_port;

  assign bist_rise  = bist_run & ~bist_run_q;
  assign burst_last = (burst_cnt == CNT_W'(MAX_BURST - 1));
  assign a_release  = ~client_a.req | bist_pending | (burst_last & client_b.req);
  assign b_release  = ~client_b.req | bist_pending | (burst_last & client_a.req);

  assign issue_a = a_gnt & client_a.req & client_a.we_n;
  assign issue_b = b_gnt & client_b.req & client_b.we_n;

  assign bist_owns_port = (state == S_BIST_DRAIN) || (state == S_BIST_START) ||
                          (state == S_BIST_WAIT);

  assign client_a.gnt        = a_gnt;
  assign client_b.gnt        = b_gnt;
  assign client_a.read_valid = tag_a[READ_LATENCY-1];
  assign client_b.read_valid = tag_b[READ_LATENCY-1];
  assign rd_data             = SRAM_read_data;

  // Port owner selects who drives the SRAM pins; an unowned port is parked as a read of address 0.
  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    if (a_gnt) begin
      SRAM_address    = client_a.address;
      SRAM_write_data = client_a.write_data;
      SRAM_we_n       = client_a.we_n;
    end else if (b_gnt) begin
      SRAM_address    = client_b.address;
      SRAM_write_data = client_b.write_data;
      SRAM_we_n       = client_b.we_n;
    end else if (bist_owns_port) begin
      SRAM_address    = BIST_address;
      SRAM_write_data = BIST_write_data;
      SRAM_we_n       = BIST_we_n;
    end
  end

  // Each issued read carries its owner tag down the pipe so read_valid lines up with the data.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tag_a <= '0;
      tag_b <= '0;
    end else begin
      tag_a[0] <= issue_a;
      tag_b[0] <= issue_b;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_a[i] <= tag_a[i-1];
        tag_b[i] <= tag_b[i-1];
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= S_IDLE;
      a_gnt        <= 1'b0;
      b_gnt        <= 1'b0;
      rr_ptr_b     <= 1'b0;
      burst_cnt    <= '0;
      phase_cnt    <= '0;
      bist_pending <= 1'b0;
      bist_run_q   <= 1'b0;
      BIST_start   <= 1'b0;
      bist_busy    <= 1'b0;
      bist_done    <= 1'b0;
      bist_fail    <= 1'b0;
    end else begin
      bist_run_q <= bist_run;
      if (bist_rise && !bist_busy) begin
        bist_pending <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (bist_pending) begin
            state        <= S_BIST_DRAIN;
            bist_pending <= 1'b0;
            bist_busy    <= 1'b1;
            bist_done    <= 1'b0;
            bist_fail    <= 1'b0;
            phase_cnt    <= '0;
          end else if (client_a.req && (!client_b.req || !rr_ptr_b)) begin
            state     <= S_GNT_A;
            a_gnt     <= 1'b1;
            burst_cnt <= '0;
          end else if (client_b.req) begin
            state     <= S_GNT_B;
            b_gnt     <= 1'b1;
            burst_cnt <= '0;
          end
        end

        S_GNT_A: begin
          if (!burst_last) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (a_release) begin
            state    <= S_IDLE;
            a_gnt    <= 1'b0;
            rr_ptr_b <= 1'b1;
          end
        end

        S_GNT_B: begin
          if (!burst_last) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (b_release) begin
            state    <= S_IDLE;
            b_gnt    <= 1'b0;
            rr_ptr_b <= 1'b0;
          end
        end

        // Let reads issued just before the handover retire before the engine starts.
        S_BIST_DRAIN: begin
          if (phase_cnt == PHASE_W'(READ_LATENCY - 1)) begin
            state      <= S_BIST_START;
            BIST_start <= 1'b1;
            phase_cnt  <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        S_BIST_START: begin
          if (phase_cnt == PHASE_W'(1)) begin
            state      <= S_BIST_WAIT;
            BIST_start <= 1'b0;
            phase_cnt  <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        // BIST_finish still shows the engine's old idle level right after start, so skip two cycles.
        S_BIST_WAIT: begin
          if (phase_cnt != PHASE_W'(2)) begin
            phase_cnt <= phase_cnt + 1'b1;
          end else if (BIST_finish) begin
            state     <= S_IDLE;
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
            bist_fail <= BIST_mismatch;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a 2-cycle SRAM model and a
// small write/read-back BIST engine model.
module tb_sram_access_arbiter;

  logic        Clock;
  logic        Resetn;
  logic        bist_run;
  logic [15:0] rd_data;
  logic        BIST_start;
  logic [17:0] BIST_address;
  logic [15:0] BIST_write_data;
  logic        BIST_we_n;
  logic        BIST_finish;
  logic        BIST_mismatch;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        bist_busy;
  logic        bist_done;
  logic        bist_fail;

  sram_access_arbiter_if a_bus ();
  sram_access_arbiter_if b_bus ();

  sram_access_arbiter #(.READ_LATENCY(2), .MAX_BURST(8)) dut (
    .Clock           (Clock),
    .Resetn          (Resetn),
    .bist_run        (bist_run),
    .client_a        (a_bus),
    .client_b        (b_bus),
    .rd_data         (rd_data),
    .BIST_start      (BIST_start),
    .BIST_address    (BIST_address),
    .BIST_write_data (BIST_write_data),
    .BIST_we_n       (BIST_we_n),
    .BIST_finish     (BIST_finish),
    .BIST_mismatch   (BIST_mismatch),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .SRAM_read_data  (SRAM_read_data),
    .bist_busy       (bist_busy),
    .bist_done       (bist_done),
    .bist_fail       (bist_fail)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic toB, input logic req, input logic weN,
                               input logic [17:0] addr, input logic [15:0] wdata);
    if (toB) begin
      b_bus.req = req; b_bus.we_n = weN; b_bus.address = addr; b_bus.write_data = wdata;
    end else begin
      a_bus.req = req; a_bus.we_n = weN; a_bus.address = addr; a_bus.write_data = wdata;
    end
  endtask

  function automatic logic [15:0] preload(input logic [17:0] addr);
    return 16'hA000 + addr[15:0] * 16'd3;
  endfunction

  function automatic logic [15:0] bistPattern(input int i);
    return 16'h5A00 | 16'(i);
  endfunction

  // SRAM model: data appears two cycles after the address; optional stuck-at-0 on bit 0 of word 5.
  logic [15:0] mem [0:262143];
  logic [15:0] pipe1;
  logic        stuck;

  function automatic logic [15:0] memRead(input logic [17:0] addr);
    logic [15:0] v;
    v = mem[addr];
    if (stuck && addr == 18'h00005) v[0] = 1'b0;
    return v;
  endfunction

  always @(posedge Clock) begin
    pipe1          <= memRead(SRAM_address);
    SRAM_read_data <= pipe1;
    if (!SRAM_we_n) mem[SRAM_address] <= SRAM_write_data;
  end

  // BIST engine model: write words 0..7, read them back, compare two cycles later.
  logic engBusy, engStartQ, engMismatch;
  int   engStep;

  assign BIST_finish     = ~engBusy;
  assign BIST_mismatch   = engMismatch;
  assign BIST_address    = (engStep < 8) ? 18'(engStep) : 18'(engStep - 8);
  assign BIST_write_data = bistPattern(engStep);
  assign BIST_we_n       = ~(engBusy && engStep < 8);

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      engBusy <= 1'b0; engStartQ <= 1'b0; engMismatch <= 1'b0; engStep <= 0;
    end else begin
      engStartQ <= BIST_start;
      if (BIST_start && !engStartQ) begin
        engBusy <= 1'b1; engStep <= 0; engMismatch <= 1'b0;
      end else if (engBusy) begin
        if (engStep >= 10 && rd_data != bistPattern(engStep - 10)) engMismatch <= 1'b1;
        if (engStep == 17) engBusy <= 1'b0;
        engStep <= engStep + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    logic [3:0] exp4;
    logic [1:0] exp2;

    for (int i = 0; i < 262144; i++) mem[i] = preload(18'(i));
    stuck = 1'b0;
    Resetn = 1'b0;
    bist_run = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 18'h0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 18'h0, 16'h0);
    repeat (3) @(negedge Clock);
    checkOutput("reset_flags", {24'd0, a_bus.gnt, b_bus.gnt, BIST_start, a_bus.read_valid,
                b_bus.read_valid, bist_busy, bist_done, bist_fail}, 32'd0);
    checkOutput("reset_we_n", {31'd0, SRAM_we_n}, 32'd1);
    Resetn = 1'b1;
    @(negedge Clock);

    // A alone: 20 reads at 0x10..0x23
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h10, 16'h0);
    for (int k = 0; k < 22; k++) begin
      @(negedge Clock);
      if (k < 20) begin
        checkOutput("t1_a_gnt", {31'd0, a_bus.gnt}, 32'd1);
        a_bus.address = 18'h10 + 18'(k);
      end else begin
        a_bus.req = 1'b0;
      end
      checkOutput("t1_a_rv", {31'd0, a_bus.read_valid}, (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) checkOutput("t1_rd_data", {16'd0, rd_data}, {16'd0, preload(18'h10 + 18'(k - 2))});
    end
    checkOutput("t1_released", {31'd0, a_bus.gnt}, 32'd0);
    checkOutput("t1_idle_mux", {13'd0, SRAM_we_n, SRAM_address}, {13'd0, 1'b1, 18'h0});
    @(negedge Clock);
    checkOutput("t1_no_extra_rv", {31'd0, a_bus.read_valid}, 32'd0);

    // Pointer now at B, B silent: A holds past MAX_BURST
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h30, 16'h0);
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge Clock);
      if (a_bus.gnt) cnt++;
    end
    checkOutput("t2_hold_cycles", 32'(cnt), 32'd14);
    checkOutput("t2_sram_addr", {14'd0, SRAM_address}, {14'd0, 18'h30});
    a_bus.req = 1'b0;
    repeat (2) @(negedge Clock);

    // Single B write moves the pointer back to A
    applyStimulus(1'b1, 1'b1, 1'b0, 18'h200, 16'hBEEF);
    @(negedge Clock);
    checkOutput("t2b_b_gnt", {31'd0, b_bus.gnt}, 32'd1);
    checkOutput("t2b_sram_bus", {SRAM_we_n, SRAM_address[14:0], SRAM_write_data}, {1'b0, 15'h200, 16'hBEEF});
    b_bus.req = 1'b0;
    @(negedge Clock);
    b_bus.we_n = 1'b1;
    checkOutput("t2b_written", {16'd0, mem[18'h200]}, {16'd0, 16'hBEEF});
    @(negedge Clock);

    // Both requesting: A 8, idle, B 8, idle, A 8
    a_bus.req = 1'b1;
    b_bus.req = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge Clock);
      exp2 = (k < 8 || k >= 18) ? 2'b10 : (k >= 9 && k <= 16) ? 2'b01 : 2'b00;
      checkOutput("t3_gnt_seq", {30'd0, a_bus.gnt, b_bus.gnt}, {30'd0, exp2});
    end
    a_bus.req = 1'b0;
    b_bus.req = 1'b0;
    repeat (2) @(negedge Clock);

    // bist_run mid-burst with fault-free SRAM
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h14, 16'h0);
    for (int k = 0; k < 11; k++) begin
      @(negedge Clock);
      if (k <= 3) a_bus.address = 18'h14 + 18'(k);
      if (k == 2) bist_run = 1'b1;
      exp4 = {k <= 3, k >= 2 && k <= 5, k >= 5, k == 7 || k == 8};
      checkOutput("t4_seq", {28'd0, a_bus.gnt, a_bus.read_valid, bist_busy, BIST_start}, {28'd0, exp4});
      if (k >= 2 && k <= 5) checkOutput("t4_rd_data", {16'd0, rd_data}, {16'd0, preload(18'h14 + 18'(k - 2))});
    end
    for (int i = 0; i < 100 && !bist_done; i++) @(negedge Clock);
    checkOutput("t4_done_fail_busy", {29'd0, bist_done, bist_fail, bist_busy}, {29'd0, 3'b100});
    checkOutput("t4_a_held_off", {31'd0, a_bus.gnt}, 32'd0);
    @(negedge Clock);
    checkOutput("t4_regrant", {31'd0, a_bus.gnt}, 32'd1);
    a_bus.req = 1'b0;
    bist_run = 1'b0;
    repeat (3) @(negedge Clock);

    // Stuck bit at word 5; second edge while busy ignored
    stuck = 1'b1;
    bist_run = 1'b1;
    for (int i = 0; i < 20 && !bist_busy; i++) @(negedge Clock);
    checkOutput("t5_busy", {31'd0, bist_busy}, 32'd1);
    checkOutput("t5_done_cleared", {31'd0, bist_done}, 32'd0);
    bist_run = 1'b0;
    @(negedge Clock);
    bist_run = 1'b1;
    for (int i = 0; i < 100 && !bist_done; i++) @(negedge Clock);
    checkOutput("t5_done_fail", {30'd0, bist_done, bist_fail}, {30'd0, 2'b11});
    repeat (6) @(negedge Clock);
    checkOutput("t5_edge_ignored", {30'd0, bist_busy, bist_done}, {30'd0, 2'b01});
    bist_run = 1'b0;
    stuck = 1'b0;
    @(negedge Clock);

    // Reset during BIST wait
    bist_run = 1'b1;
    for (int i = 0; i < 20 && !BIST_start; i++) @(negedge Clock);
    checkOutput("t6_start_seen", {31'd0, BIST_start}, 32'd1);
    repeat (4) @(negedge Clock);
    checkOutput("t6_in_wait", {31'd0, bist_busy}, 32'd1);
    Resetn = 1'b0;
    #1;
    checkOutput("t6_reset_async", {24'd0, a_bus.gnt, b_bus.gnt, BIST_start, a_bus.read_valid,
                b_bus.read_valid, bist_busy, bist_done, bist_fail}, 32'd0);
    bist_run = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    checkOutput("t6_after_release", {30'd0, bist_busy, BIST_start}, 32'd0);

    // Reset during an A read burst: in-flight tags must vanish
    applyStimulus(1'b0, 1'b1, 1'b1, 18'h18, 16'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      a_bus.address = 18'h18 + 18'(k);
    end
    checkOutput("t6b_rv_before", {31'd0, a_bus.read_valid}, 32'd1);
    Resetn = 1'b0;
    #1;
    checkOutput("t6b_reset_async", {30'd0, a_bus.gnt, a_bus.read_valid}, 32'd0);
    a_bus.req = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      if (a_bus.read_valid) cnt++;
    end
    checkOutput("t6b_no_stale_rv", 32'(cnt), 32'd0);

    // Fresh BIST pass after reset
    bist_run = 1'b1;
    for (int i = 0; i < 100 && !bist_done; i++) @(negedge Clock);
    checkOutput("t6c_done_fail", {30'd0, bist_done, bist_fail}, {30'd0, 2'b10});

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
